drum_sample_fifo: RTL and testbench
===================================

# drum_sample_fifo

Buffers drum-membrane samples between the node grid and the audio output path. It captures the signed 18-bit center-node amplitude each time the grid finishes an update, and holds it in a circular FIFO. It scales each sample to a 32-bit audio word and serves it on a request/valid handshake from the audio side. It throttles the grid through `start_update`, so the grid only computes new time steps while there is buffer room.

## Interface
- `DEPTH_POW`, 4: FIFO depth is 2^DEPTH_POW entries.
- `PRIME_LEVEL`, 8: occupancy required before audio is served (1..2^DEPTH_POW).
- `HIGH_WATER`, 14: `start_update` deasserts when occupancy ≥ this value.
- `GAIN_SHIFT`, 14: left shift applied to the sign-extended sample (0..14).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `sample_in`  in  18  signed amplitude from the grid's `center_node_amp`.
- `sample_strobe`  in  1  one-cycle pulse from the grid's `done_update_to_fifo`; qualifies `sample_in`.
- `start_update`  out  1  to the grid; high = grid may begin the next update.
- `audio_req`  in  1  one-cycle pull request from the audio side.
- `audio_data`  out  32  scaled sample.
- `audio_valid`  out  1  one-cycle pulse; `audio_data` is valid.
- `fifo_count`  out  DEPTH_POW+1  current occupancy, 0..2^DEPTH_POW.
- `overflow_cnt`  out  16  saturating count of dropped samples.
- `underflow_cnt`  out  16  saturating count of requests served while empty.

## Operation
- **Storage:** circular buffer with write pointer, read pointer and occupancy counter.
  - Pointers are DEPTH_POW bits and wrap modulo depth.
  - Full = count equals 2^DEPTH_POW. Empty = count is 0.
- **States:** PRIME and RUN. Reset enters PRIME.
  - PRIME → RUN when the registered count ≥ PRIME_LEVEL.
  - RUN → PRIME on an underflow event.
- **Write:** on `sample_strobe`, `sample_in` is written at the write pointer, the pointer increments and the count increments.
  - If full and no read occurs in the same cycle, the sample is dropped and `overflow_cnt` increments (saturating at 16'hFFFF).
- **Read (RUN, not empty):** on `audio_req`, the entry at the read pointer is popped.
  - `audio_data` = ({{14{s[17]}}, s} <<< GAIN_SHIFT), truncated to 32 bits.
  - `audio_valid` pulses, and the popped sample becomes the "last sample".
- **Read (RUN, empty):** underflow event.
  - `audio_data` = last sample, scaled. `audio_valid` still pulses.
  - `underflow_cnt` increments (saturating). The state returns to PRIME.
- **Read (PRIME):** `audio_req` is answered with `audio_data` = last sample scaled (0 after reset) and an `audio_valid` pulse.
  - Nothing is popped and no underflow is counted.
- **Simultaneous write and read in RUN:**
  - Non-empty: both occur and the count is unchanged.
  - Full: the write is accepted because the read frees a slot; no overflow.
  - Empty: counts as underflow. The write is stored and the count becomes 1. No bypass.
- **Throttle:** `start_update` is a register loaded each cycle with (next count < HIGH_WATER). This is independent of state.

## Timing
- **Reset values:**
  - `audio_data`=0, `audio_valid`=0, `start_update`=0, `fifo_count`=0.
  - Both error counters = 0. State = PRIME. Pointers = 0. Last sample = 0.
  - Memory contents are don't-care.
- `start_update` rises on the first clock edge after reset deasserts.
- **Write:** a strobe sampled at edge n is reflected in `fifo_count` after edge n.
- **Read:** a request sampled at edge n drives `audio_data`/`audio_valid` registered at edge n, visible in the following cycle. Latency is 1 cycle.
- `audio_valid` is high for exactly one cycle per request. Back-to-back requests give back-to-back valids.
- **State transitions:**
  - The PRIME→RUN check uses the count registered before the edge. A request in the same cycle as the transition is still handled as PRIME.
  - The RUN→PRIME transition takes effect on the edge of the underflow.
- **Throttle latency:** `start_update` falls on the edge where the count reaches HIGH_WATER. At most one sample already in flight from the grid then arrives; it is absorbed because HIGH_WATER < depth.
- **Reset mid-operation:** all registers clear immediately (asynchronous). Any in-flight request gets no `audio_valid`.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles, then release → all outputs 0 during reset; `start_update`=1 one cycle after release; state PRIME.
- **Prime then serve:** 8 strobes with `sample_in`=1..8, then 8 requests → `audio_valid` pulses carry 1<<<14 through 8<<<14 in order; `fifo_count` returns to 0.
- **Negative scaling:** write -17 (18'h3FFEF), prime, then request → `audio_data`=32'hFFFBC000.
- **Throttle and overflow:** 18 strobes with no requests → `start_update` falls when the count reaches 14; count saturates at 16; `overflow_cnt`=2; pointer wrap verified by reading back the first 16 values in order.
- **Underflow:** prime with 8 samples, then 9 requests → the 9th returns the 8th sample scaled with `audio_valid`=1; `underflow_cnt`=1; state PRIME, and requests then pop nothing until 8 new samples arrive.
- **Simultaneous and full:** fill to 16, then strobe and request in the same cycle → count stays 16, `overflow_cnt` unchanged, and the oldest sample is output.

Source files
------------

// File: rtl/drum_sample_fifo_if.sv
// Grid-side and audio-side signals of the drum sample FIFO.
// master = grid/audio environment, slave = the FIFO itself.
interface drum_sample_fifo_if #(
  parameter int DEPTH_POW = 4
);
  logic [17:0]        sample_in;
  logic               sample_strobe;
  logic               start_update;
  logic               audio_req;
  logic [31:0]        audio_data;
  logic               audio_valid;
  logic [DEPTH_POW:0] fifo_count;
  logic [15:0]        overflow_cnt;
  logic [15:0]        underflow_cnt;

  modport master (
    output sample_in, sample_strobe, audio_req,
    input  start_update, audio_data, audio_valid, fifo_count,
           overflow_cnt, underflow_cnt
  );

  modport slave (
    input  sample_in, sample_strobe, audio_req,
    output start_update, audio_data, audio_valid, fifo_count,
           overflow_cnt, underflow_cnt
  );
endinterface

// File: rtl/drum_sample_fifo.sv
// Circular FIFO of center-node samples between the drum grid and audio output.
// Serves scaled samples on request once primed and throttles the grid near full.
module drum_sample_fifo #(
  parameter int DEPTH_POW   = 4,
  parameter int PRIME_LEVEL = 8,
  parameter int HIGH_WATER  = 14,
  parameter int GAIN_SHIFT  = 14
) (
  input  logic               clk,
  input  logic               reset,
  drum_sample_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_POW;
  localparam logic [DEPTH_POW:0] DEPTH_C = (DEPTH_POW+1)'(DEPTH);
  localparam logic [DEPTH_POW:0] PRIME_C = (DEPTH_POW+1)'(PRIME_LEVEL);
  localparam logic [DEPTH_POW:0] HIGH_C  = (DEPTH_POW+1)'(HIGH_WATER);

  typedef enum logic {PRIME, RUN} state_t;

  state_t               state;
  logic [17:0]          mem [DEPTH];
  logic [DEPTH_POW-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_POW:0]   count, count_nxt;
  logic [17:0]          last_smp, rd_smp;
  logic [31:0]          audio_data;
  logic                 audio_valid, start_update;
  logic [15:0]          ovf_cnt, unf_cnt;
  logic                 empty, full, pop, unf, wr_en, drop;

  function automatic logic [31:0] scale(input logic [17:0] s);
    logic [31:0] ext;
    ext = {{14{s[17]}}, s};
    return ext << GAIN_SHIFT;
  endfunction

  always_comb begin
    empty  = (count == '0);
    full   = (count == DEPTH_C);
    pop    = (state == RUN) && bus.audio_req && !empty;
    unf    = (state == RUN) && bus.audio_req && empty;
    // a pop in the same cycle frees the slot a full-buffer write needs
    wr_en  = bus.sample_strobe && (!full || pop);
    drop   = bus.sample_strobe && full && !pop;
    rd_smp = pop ? mem[rd_ptr] : last_smp;
    count_nxt = count;
    case ({wr_en, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // storage has no reset; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.sample_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= PRIME;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      last_smp     <= '0;
      audio_data   <= '0;
      audio_valid  <= 1'b0;
      start_update <= 1'b0;
      ovf_cnt      <= '0;
      unf_cnt      <= '0;
    end else begin
      count        <= count_nxt;
      start_update <= (count_nxt < HIGH_C);
      audio_valid  <= bus.audio_req;
      if (bus.audio_req) audio_data <= scale(rd_smp);
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_smp <= mem[rd_ptr];
      end
      if (drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;
      if (unf && unf_cnt != 16'hFFFF)  unf_cnt <= unf_cnt + 1'b1;
      case (state)
        PRIME:   if (count >= PRIME_C) state <= RUN;
        RUN:     if (unf) state <= PRIME;
        default: state <= PRIME;
      endcase
    end
  end

  assign bus.audio_data    = audio_data;
  assign bus.audio_valid   = audio_valid;
  assign bus.start_update  = start_update;
  assign bus.fifo_count    = count;
  assign bus.overflow_cnt  = ovf_cnt;
  assign bus.underflow_cnt = unf_cnt;
endmodule

// File: tb/tb_drum_sample_fifo.sv
// Directed bench for drum_sample_fifo: expected audio words are queued when a
// request is driven and compared as each audio_valid arrives.
module tb_drum_sample_fifo;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  drum_sample_fifo_if #(.DEPTH_POW(4)) bus ();

  drum_sample_fifo #(
    .DEPTH_POW(4), .PRIME_LEVEL(8), .HIGH_WATER(14), .GAIN_SHIFT(14)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] sc(input int v);
    logic [31:0] w;
    w = 32'(v);
    return w << 14;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic s, input int d, input logic r, input logic [31:0] e);
    @(negedge clk);
    bus.sample_strobe = s;
    bus.sample_in     = 18'(d);
    bus.audio_req     = r;
    if (r) exp_q.push_back(e);
  endtask

  task automatic idle();
    cyc(1'b0, 0, 1'b0, 32'h0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every valid must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset && bus.audio_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL spurious_valid observed=%h expected=no valid", bus.audio_data);
      end else begin
        chk("audio_data", bus.audio_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.sample_strobe = 1'b0;
    bus.sample_in     = '0;
    bus.audio_req     = 1'b0;

    // reset
    repeat (3) @(negedge clk);
    chk("rst_audio_data", bus.audio_data, 32'h0);
    chk("rst_audio_valid", 32'(bus.audio_valid), 32'h0);
    chk("rst_start_update", 32'(bus.start_update), 32'h0);
    chk("rst_fifo_count", 32'(bus.fifo_count), 32'h0);
    chk("rst_overflow", 32'(bus.overflow_cnt), 32'h0);
    chk("rst_underflow", 32'(bus.underflow_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    settle();
    chk("start_after_rst", 32'(bus.start_update), 32'h1);

    // request while priming returns reset last sample
    cyc(1'b0, 0, 1'b1, sc(0));
    idle();

    // prime then serve
    for (int i = 1; i <= 8; i++) cyc(1'b1, i, 1'b0, 32'h0);
    idle();
    settle();
    chk("primed_count", 32'(bus.fifo_count), 32'd8);
    for (int i = 1; i <= 8; i++) cyc(1'b0, 0, 1'b1, sc(i));
    idle();
    settle();
    chk("served_count", 32'(bus.fifo_count), 32'd0);

    // underflow returns last sample and drops back to PRIME
    for (int i = 11; i <= 18; i++) cyc(1'b1, i, 1'b0, 32'h0);
    idle();
    for (int i = 11; i <= 18; i++) cyc(1'b0, 0, 1'b1, sc(i));
    cyc(1'b0, 0, 1'b1, sc(18));
    idle();
    settle();
    chk("underflow_cnt", 32'(bus.underflow_cnt), 32'd1);
    chk("unf_count", 32'(bus.fifo_count), 32'd0);
    cyc(1'b0, 0, 1'b1, sc(18));
    idle();
    settle();
    chk("prime_no_unf", 32'(bus.underflow_cnt), 32'd1);

    // negative scaling; PRIME request does not pop
    cyc(1'b1, -17, 1'b0, 32'h0);
    idle();
    cyc(1'b0, 0, 1'b1, sc(18));
    idle();
    settle();
    chk("prime_no_pop", 32'(bus.fifo_count), 32'd1);
    for (int i = 21; i <= 27; i++) cyc(1'b1, i, 1'b0, 32'h0);
    idle();
    cyc(1'b0, 0, 1'b1, 32'hFFFBC000);
    for (int i = 21; i <= 27; i++) cyc(1'b0, 0, 1'b1, sc(i));
    idle();
    settle();
    chk("neg_drained", 32'(bus.fifo_count), 32'd0);

    // throttle and overflow
    for (int k = 1; k <= 18; k++) begin
      cyc(1'b1, 100 + k - 1, 1'b0, 32'h0);
      settle();
      chk("throttle", 32'(bus.start_update), (k < 14) ? 32'h1 : 32'h0);
      chk("fill_count", 32'(bus.fifo_count), (k > 16) ? 32'd16 : 32'(k));
    end
    idle();
    settle();
    chk("overflow_cnt", 32'(bus.overflow_cnt), 32'd2);
    for (int i = 0; i < 16; i++) cyc(1'b0, 0, 1'b1, sc(100 + i));
    idle();
    settle();
    chk("wrap_drained", 32'(bus.fifo_count), 32'd0);
    chk("throttle_release", 32'(bus.start_update), 32'h1);

    // simultaneous write and read while full
    for (int i = 0; i < 16; i++) cyc(1'b1, 200 + i, 1'b0, 32'h0);
    cyc(1'b1, 216, 1'b1, sc(200));
    idle();
    settle();
    chk("full_rw_count", 32'(bus.fifo_count), 32'd16);
    chk("full_rw_ovf", 32'(bus.overflow_cnt), 32'd2);
    for (int i = 1; i <= 16; i++) cyc(1'b0, 0, 1'b1, sc(200 + i));
    idle();
    settle();
    chk("full_drained", 32'(bus.fifo_count), 32'd0);
    chk("full_no_unf", 32'(bus.underflow_cnt), 32'd1);

    // reset mid-operation kills the in-flight request
    cyc(1'b1, 300, 1'b0, 32'h0);
    @(negedge clk);
    bus.sample_strobe = 1'b0;
    bus.audio_req = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    bus.audio_req = 1'b0;
    chk("midrst_valid", 32'(bus.audio_valid), 32'h0);
    chk("midrst_count", 32'(bus.fifo_count), 32'h0);
    chk("midrst_ovf", 32'(bus.overflow_cnt), 32'h0);
    chk("midrst_unf", 32'(bus.underflow_cnt), 32'h0);
    chk("midrst_start", 32'(bus.start_update), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) idle();

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL missing_valid observed=%0d outstanding expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
